name_table_writer: RTL and testbench
====================================

Name: name_table_writer

Overview:
- Write-side engine for the background tile-name RAM.
- Accepts tile commands over a valid/ready handshake: single tile, rectangle fill, or full clear.
- Emits one name-RAM write per cycle on the RAM's second (write) port, while the background renderer reads the other port.
- Addresses use the renderer's layout: addr = {row[4:0], col[5:0]}, 8x8-pixel tiles, 40x30 visible grid.

Parameters:
- COLS, 40, visible tile columns; valid columns are 0..COLS-1, COLS <= 64.
- ROWS, 30, visible tile rows; valid rows are 0..ROWS-1, ROWS <= 32.
- ADDR_W, 11, name-RAM address width; equals 5 row bits + 6 column bits.
- DATA_W, 8, tile index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  00 single tile, 01 rectangle fill, 10 clear screen, 11 reserved.
- cmd_col  in  6  start column.
- cmd_row  in  5  start row.
- cmd_w  in  6  rectangle width in tiles (op 01 only).
- cmd_h  in  5  rectangle height in tiles (op 01 only).
- cmd_tile  in  DATA_W  tile index to write.
- write_allow  in  1  write permission, e.g. vblank; writes stall while low.
- wr_en  out  1  name-RAM write strobe.
- wr_addr  out  ADDR_W  {row, col}.
- wr_data  out  DATA_W  tile index.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on command completion.

Behaviour:
- Reset (synchronous): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - cmd_ready=0 while rst is high, 1 on the first cycle after.
  - Reset mid-operation aborts immediately: no further writes, no done pulse.
- FSM states: IDLE, WRITE, FINISH.
- IDLE:
  - cmd_ready=1.
  - Command accepted on cycle T when cmd_valid && cmd_ready.
  - Operands are latched and the effective rectangle is computed:
    - op 00: (col, row, 1, 1).
    - op 01: (col, row, w, h).
    - op 10: (0, 0, COLS, ROWS); cmd_col/row/w/h ignored.
    - op 11: zero-size.
  - Clipping at accept:
    - w_eff = 0 if col >= COLS, else min(w, COLS-col).
    - h_eff = 0 if row >= ROWS, else min(h, ROWS-row).
  - If w_eff==0 or h_eff==0: go to FINISH with no writes. Otherwise go to WRITE.
  - busy=1 from T+1.
- WRITE:
  - cmd_ready=0.
  - Traversal is row-major: column counter from col to col+w_eff-1, then row increments and column reloads to col.
  - Each cycle with write_allow=1 registers exactly one write: wr_en=1, wr_addr={cur_row, cur_col}, wr_data=latched tile.
  - Counters then advance.
  - With write_allow=0: wr_en=0 and the counters hold, with no skip and no duplicate.
  - The first write appears at cycle T+1 if write_allow=1 at T+1.
  - After the write at (col+w_eff-1, row+h_eff-1), go to FINISH.
- FINISH:
  - done=1 for exactly one cycle; wr_en=0; busy=0 on the following cycle.
  - Return to IDLE; cmd_ready=1 the cycle after done.
- Total writes equal w_eff*h_eff.
  - Minimum latency from accept to done is w_eff*h_eff+1 cycles.
  - A zero-size command gives done at T+1.
- Column/row arithmetic uses 7-/6-bit intermediates so that col+w does not wrap.
  - wr_addr never exceeds row ROWS-1 or col COLS-1.
- cmd_* inputs are ignored outside acceptance; changing them mid-command has no effect.
- wr_en is never high in IDLE or FINISH.

Test Plan:
- Single tile: op=00, col=5, row=3, tile=0xA7, write_allow=1.
  - Response: exactly one write at T+1, addr=0x0C5, data=0xA7; done at T+2; cmd_ready=1 at T+3.
- Rectangle: op=01, col=38, row=28, w=4, h=4, tile=0x11.
  - Clipped to 2x2.
  - Response: writes to addrs 0x726, 0x727, 0x766, 0x767 in that order; exactly 4 writes; then done.
- Clear: op=10, tile=0x00.
  - Response: 1200 writes covering rows 0-29 and cols 0-39 row-major; no address with col >= 40; done once after the last write (0x767).
- Stall: rectangle 3x1 at (0,0) with write_allow toggling 1,0,0,1,0,1.
  - Response: writes to 0x000, 0x001, 0x002 only on the allowed cycles, with no duplicates; done after the third write.
- Zero/out-of-range: op=01 with w=0, then op=00 with col=45, then op=11.
  - Response: no wr_en for any of them; each gives done one cycle after accept.
- Reset mid-fill: assert rst during the 10th write of a clear.
  - Response: wr_en=0 and busy=0 from the reset cycle; no done pulse; cmd_ready=1 after rst deasserts; a new single-tile command then works normally.

Source files
------------

// File: rtl/name_table_if.sv
// name_table_if: tile command handshake plus name-RAM write port
interface name_table_if #(parameter int ADDR_W = 11, parameter int DATA_W = 8);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_col;
  logic [4:0] cmd_row;
  logic [5:0] cmd_w;
  logic [4:0] cmd_h;
  logic [DATA_W-1:0] cmd_tile;
  logic write_allow;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic busy;
  logic done;
  modport master (
    output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_w, cmd_h, cmd_tile, write_allow,
    input cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_col, cmd_row, cmd_w, cmd_h, cmd_tile, write_allow,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/name_table_writer.sv
// name_table_writer: turns tile commands into one name-RAM write per cycle
module name_table_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  name_table_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
  localparam logic [6:0] COLS7 = 7'(COLS);
  localparam logic [5:0] ROWS6 = 6'(ROWS);
  state_t state;
  logic [5:0] col0, cur_col, col_end;
  logic [4:0] cur_row, row_end;
  logic [DATA_W-1:0] tile;
  logic [6:0] c7, w7, w_eff;
  logic [5:0] r6, h6, h_eff;
  // effective rectangle of the offered command, clipped to the visible grid
  always_comb begin
    c7 = bus.cmd_op == 2'b10 ? 7'd0 : {1'b0, bus.cmd_col};
    r6 = bus.cmd_op == 2'b10 ? 6'd0 : {1'b0, bus.cmd_row};
    w7 = bus.cmd_op == 2'b00 ? 7'd1 : bus.cmd_op == 2'b01 ? {1'b0, bus.cmd_w} : bus.cmd_op == 2'b10 ? COLS7 : 7'd0;
    h6 = bus.cmd_op == 2'b00 ? 6'd1 : bus.cmd_op == 2'b01 ? {1'b0, bus.cmd_h} : bus.cmd_op == 2'b10 ? ROWS6 : 6'd0;
    w_eff = c7 >= COLS7 ? 7'd0 : w7 > COLS7 - c7 ? COLS7 - c7 : w7;
    h_eff = r6 >= ROWS6 ? 6'd0 : h6 > ROWS6 - r6 ? ROWS6 - r6 : h6;
  end
  // command FSM: latch at accept, walk the rectangle row-major, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col0 <= '0;
      cur_col <= '0;
      cur_row <= '0;
      col_end <= '0;
      row_end <= '0;
      tile <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          col0 <= c7[5:0];
          cur_col <= c7[5:0];
          cur_row <= r6[4:0];
          col_end <= c7[5:0] + w_eff[5:0] - 6'd1;
          row_end <= r6[4:0] + h_eff[4:0] - 5'd1;
          tile <= bus.cmd_tile;
          state <= (w_eff == 7'd0 || h_eff == 6'd0) ? FINISH : WRITE;
        end
        WRITE: if (bus.write_allow) begin
          if (cur_col == col_end) begin
            cur_col <= col0;
            if (cur_row == row_end) state <= FINISH;
            else cur_row <= cur_row + 5'd1;
          end else cur_col <= cur_col + 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = state == IDLE && !rst;
  assign bus.wr_en = state == WRITE && bus.write_allow && !rst;
  assign bus.wr_addr = ADDR_W'({cur_row, cur_col});
  assign bus.wr_data = tile;
  assign bus.busy = state != IDLE && !rst;
  assign bus.done = state == FINISH && !rst;
endmodule

// File: tb/tb_name_table_writer.sv
// tb_name_table_writer: directed checks of the name-table write engine
module tb_name_table_writer;
  logic clk;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int n, cyc, bad, colbad;
  logic [10:0] wa [0:1299];
  logic [7:0] wd [0:1299];
  logic [5:0] pat;
  name_table_if #(.ADDR_W(11), .DATA_W(8)) bus();
  name_table_writer #(.COLS(40), .ROWS(30), .ADDR_W(11), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] col, input logic [4:0] row,
                      input logic [5:0] w, input logic [4:0] h, input logic [7:0] t);
    bus.cmd_op = op;
    bus.cmd_col = col;
    bus.cmd_row = row;
    bus.cmd_w = w;
    bus.cmd_h = h;
    bus.cmd_tile = t;
    bus.cmd_valid = 1;
    #1 chk("accept_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 0;
    bus.cmd_op = 2'($urandom);
    bus.cmd_col = 6'($urandom);
    bus.cmd_row = 5'($urandom);
    bus.cmd_w = 6'($urandom);
    bus.cmd_h = 5'($urandom);
    bus.cmd_tile = 8'($urandom);
    #1;
  endtask

  task automatic collect(input string tag);
    n = 0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      if (bus.wr_en === 1'b1 && n < 1300) begin
        wa[n] = bus.wr_addr;
        wd[n] = bus.wr_data;
        n++;
      end
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_wr_en_at_done"}, bus.wr_en, 0);
  endtask

  initial begin
    rst = 1;
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_col = 0;
    bus.cmd_row = 0;
    bus.cmd_w = 0;
    bus.cmd_h = 0;
    bus.cmd_tile = 0;
    bus.write_allow = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("post_rst_ready", bus.cmd_ready, 1);
    @(negedge clk);

    // single tile
    send(2'b00, 6'd5, 5'd3, 6'd0, 5'd0, 8'hA7);
    chk("single_wr_en", bus.wr_en, 1);
    chk("single_addr", bus.wr_addr, 11'h0C5);
    chk("single_data", bus.wr_data, 8'hA7);
    chk("single_busy", bus.busy, 1);
    chk("single_ready_busy", bus.cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("single_done", bus.done, 1);
    chk("single_no_wr", bus.wr_en, 0);
    chk("single_busy_fin", bus.busy, 1);
    @(negedge clk);
    #1;
    chk("single_ready_after", bus.cmd_ready, 1);
    chk("single_done_once", bus.done, 0);
    chk("single_busy_after", bus.busy, 0);
    @(negedge clk);

    // clipped rectangle
    send(2'b01, 6'd38, 5'd28, 6'd4, 5'd4, 8'h11);
    collect("rect");
    chk("rect_count", n, 4);
    chk("rect_latency", cyc, 4);
    chk("rect_a0", wa[0], 11'h726);
    chk("rect_a1", wa[1], 11'h727);
    chk("rect_a2", wa[2], 11'h766);
    chk("rect_a3", wa[3], 11'h767);
    chk("rect_data", {wd[0], wd[1], wd[2], wd[3]}, 32'h11111111);
    @(negedge clk);
    #1;
    chk("rect_done_once", bus.done, 0);
    chk("rect_ready_after", bus.cmd_ready, 1);
    @(negedge clk);

    // full clear, operand fields must be ignored
    send(2'b10, 6'd7, 5'd9, 6'd1, 5'd1, 8'h00);
    collect("clear");
    chk("clear_count", n, 1200);
    chk("clear_latency", cyc, 1200);
    bad = 0;
    colbad = 0;
    for (int i = 0; i < 1200; i++) begin
      if (wa[i] !== {5'(i / 40), 6'(i % 40)} || wd[i] !== 8'h00) bad++;
      if (wa[i][5:0] >= 6'd40) colbad++;
    end
    chk("clear_order", bad, 0);
    chk("clear_col_range", colbad, 0);
    chk("clear_last", wa[1199], 11'h767);
    @(negedge clk);
    #1;
    chk("clear_done_once", bus.done, 0);
    @(negedge clk);

    // stalled 3x1 rectangle
    pat = 6'b101001;
    n = 0;
    send(2'b01, 6'd0, 5'd0, 6'd3, 5'd1, 8'h5C);
    for (int i = 0; i < 6; i++) begin
      bus.write_allow = pat[i];
      #1 chk("stall_wr_en", bus.wr_en, {31'd0, pat[i]});
      chk("stall_no_early_done", bus.done, 0);
      if (bus.wr_en === 1'b1) begin
        wa[n] = bus.wr_addr;
        n++;
      end
      @(negedge clk);
    end
    bus.write_allow = 1;
    #1;
    chk("stall_done", bus.done, 1);
    chk("stall_count", n, 3);
    chk("stall_a0", wa[0], 11'h000);
    chk("stall_a1", wa[1], 11'h001);
    chk("stall_a2", wa[2], 11'h002);
    @(negedge clk);
    @(negedge clk);

    // zero-size and out-of-range commands
    send(2'b01, 6'd2, 5'd2, 6'd0, 5'd3, 8'h22);
    chk("zero_w_wr_en", bus.wr_en, 0);
    chk("zero_w_done", bus.done, 1);
    @(negedge clk);
    #1 chk("zero_w_ready", bus.cmd_ready, 1);
    send(2'b00, 6'd45, 5'd1, 6'd0, 5'd0, 8'h33);
    chk("oor_col_wr_en", bus.wr_en, 0);
    chk("oor_col_done", bus.done, 1);
    @(negedge clk);
    #1 chk("oor_col_ready", bus.cmd_ready, 1);
    send(2'b11, 6'd1, 5'd1, 6'd1, 5'd1, 8'h44);
    chk("op11_wr_en", bus.wr_en, 0);
    chk("op11_done", bus.done, 1);
    @(negedge clk);
    #1 chk("op11_ready", bus.cmd_ready, 1);
    @(negedge clk);

    // reset in the middle of a clear
    send(2'b10, 6'd0, 5'd0, 6'd0, 5'd0, 8'h3C);
    repeat (9) @(negedge clk);
    #1;
    chk("mid_tenth_wr", bus.wr_en, 1);
    chk("mid_tenth_addr", bus.wr_addr, 11'd9);
    rst = 1;
    #1;
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_post_ready", bus.cmd_ready, 1);
    chk("mid_post_wr_en", bus.wr_en, 0);
    chk("mid_post_busy", bus.busy, 0);
    chk("mid_post_done", bus.done, 0);
    @(negedge clk);
    #1 chk("mid_still_idle", bus.wr_en | bus.done | bus.busy, 0);
    send(2'b00, 6'd39, 5'd29, 6'd0, 5'd0, 8'hEE);
    chk("mid_new_wr_en", bus.wr_en, 1);
    chk("mid_new_addr", bus.wr_addr, 11'h767);
    chk("mid_new_data", bus.wr_data, 8'hEE);
    @(negedge clk);
    #1 chk("mid_new_done", bus.done, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
